router_port: RTL and testbench
==============================

Name: router_port

Overview:
Router-side endpoint of the byte-serial node<->router link. It is the peer of the node's serializer and deserializer.
- RX path: deserializes 4-byte packets from the node into a small packet FIFO and presents whole packets to the router core with valid/ready.
- TX path: accepts whole packets from the router core and serializes them to the node.
- One instance per router port; the router core/crossbar sits behind it.

Parameters:
RX_DEPTH, 2, packet slots in RX FIFO (power of 2, >=2)

Ports:
clock  input  1  clock
reset_n  input  1  synchronous active-low reset
free_outbound  output  1  router can accept a new packet from node (registered)
put_outbound  input  1  node driving a valid byte this cycle
payload_outbound  input  8  byte from node
free_inbound  input  1  node can accept a new packet
put_inbound  output  1  router driving a valid byte (registered)
payload_inbound  output  8  byte to node (registered)
rx_pkt  output  32 (pkt_t)  head packet of RX FIFO
rx_valid  output  1  rx_pkt valid
rx_ready  input  1  core consumes rx_pkt this cycle
tx_pkt  input  32 (pkt_t)  packet from core
tx_valid  input  1  tx_pkt valid
tx_ready  output  1  TX path can accept tx_pkt
rx_err  output  1  one-cycle pulse on protocol violation

Behaviour:
Reset and decided interface:
- Reset reset_n: synchronous, active-low. Clock: clock.
- Reset values: free_outbound=0, put_inbound=0, payload_inbound=0, rx_valid=0, tx_ready=0, rx_err=0. FIFO empty, both FSMs idle.
- First cycle after reset: free_outbound=1, tx_ready=1.

Wire format:
- byte0={src,dest}, byte1=data[23:16], byte2=data[15:8], byte3=data[7:0].
- A packet is 4 bytes on 4 consecutive put cycles.
- A sender may start a packet (byte0) only in a cycle where the peer's free is 1. Bytes 1-3 ignore free.

RX FSM (RX_IDLE, RX_B1, RX_B2, RX_B3):
- RX_IDLE & put_outbound & free_outbound: capture byte0, reserve one FIFO slot, go RX_B1.
- RX_IDLE & put_outbound & !free_outbound: byte dropped, rx_err pulse, stay RX_IDLE.
- RX_Bn & put_outbound: capture byte n. RX_B3 pushes the assembled packet into the reserved slot (rx_valid can rise the next cycle), then goes RX_IDLE.
- RX_Bn & !put_outbound: discard partial packet, release reservation, rx_err pulse, go RX_IDLE.
- free_outbound <= (next_count + next_reserved) < RX_DEPTH.
- A new packet may begin in the cycle right after byte3 if space allows.

RX FIFO:
- rx_valid = !empty. rx_pkt is combinational from head.
- Pop on rx_valid & rx_ready.
- Push and pop in the same cycle is legal at any occupancy, including full; count is unchanged.
- Pointers wrap modulo RX_DEPTH. No overflow is possible because of reservation.

TX FSM (TX_IDLE, TX_WAIT, TX_SEND):
- tx_ready=1 only in TX_IDLE.
- tx_valid & tx_ready: latch tx_pkt, go TX_WAIT.
- TX_WAIT & free_inbound: next edge drives put_inbound=1 with payload=byte0, go TX_SEND.
- TX_SEND drives bytes 1,2,3 on the next three edges with put_inbound=1, then TX_IDLE with put_inbound=0.
- put_inbound is low for at least 2 cycles between packets.
- payload_inbound holds its last value when put_inbound=0.

Reset mid-operation: all partial state is discarded, and outputs return to their reset values on the next edge.

Optional Feature:
ROUTER_PORT_STATS_EN
- Defined: adds outputs rx_count[15:0] and tx_count[15:0].
  - rx_count increments on each completed RX push; tx_count on each byte3 sent.
  - Both reset to 0 and wrap at 16 bits. rx_err events are not counted.
- Undefined: ports and logic are absent.

Decomposition:
- Shared package: pkt_t {src[3:0], dest[3:0], data[23:0]}, PKT_BYTES=4, RX/TX state enums.
- One sub-module: router_port_pktfifo (parameterized depth, pkt_t width, push/pop/count). Both FSMs stay in router_port.

Test Plan:
- Single RX: node sends bytes 8'h12,8'hAB,8'hCD,8'hEF on 4 put cycles, free held -> rx_valid=1 one cycle after byte3, rx_pkt={4'h1,4'h2,24'hABCDEF}.
- RX backpressure: rx_ready=0, send 2 packets -> free_outbound=0 after byte0 of the 2nd packet. A 3rd byte0 attempt while free_outbound=0 -> rx_err pulse, FIFO count stays 2. Pop one -> free_outbound=1 next cycle.
- Truncated RX: put high for 2 cycles then low -> rx_err 1 cycle, rx_valid stays 0, the next full packet is received correctly.
- TX: tx_pkt=32'h34_0102_03 with free_inbound=1 -> put_inbound=1 for 4 cycles carrying 34,01,02,03. tx_ready low until after byte3.
- TX wait: free_inbound=0 for 5 cycles after accept -> put_inbound stays 0. Raise free -> byte0 on the next edge. Dropping free after byte0 does not stall bytes 1-3.
- Reset mid-packet: assert reset_n=0 during RX_B2 and TX_SEND -> next edge put_inbound=0, free_outbound=0, rx_valid=0. After release, a fresh packet completes normally.

Source files
------------

// File: rtl/router_port_pkg.sv
// Shared types for the router-side byte-serial link endpoint: packet layout,
// wire packet length and the RX/TX state encodings.
package router_port_pkg;

    localparam int PKT_BYTES = 4;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_B1   = 2'd1,
        RX_B2   = 2'd2,
        RX_B3   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1,
        TX_SEND = 2'd2
    } tx_state_t;

    // Wire byte n of a packet; byte0 is {src,dest}.
    function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
        logic [31:0] w;
        w = p;
        case (idx)
            2'd0:    pkt_byte = w[31:24];
            2'd1:    pkt_byte = w[23:16];
            2'd2:    pkt_byte = w[15:8];
            default: pkt_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/router_port_pktfifo.sv
// Whole-packet FIFO for the RX path. Push and pop may coincide at any
// occupancy, including full; the caller guarantees no push into a full FIFO.
module router_port_pktfifo
    import router_port_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  pkt_t                     push_pkt,
    input  logic                     pop,
    output pkt_t                     head_pkt,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pkt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head_pkt = mem[rd_ptr];
    assign empty    = (count == '0);

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_pkt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_port.sv
// Router-side endpoint of the node<->router byte-serial link: RX deserializer
// with packet FIFO, TX serializer. Optional counters under ROUTER_PORT_STATS_EN.
module router_port
    import router_port_pkg::*;
#(
    parameter int RX_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        free_outbound,
    input  logic        put_outbound,
    input  logic [7:0]  payload_outbound,
    input  logic        free_inbound,
    output logic        put_inbound,
    output logic [7:0]  payload_inbound,
    output pkt_t        rx_pkt,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  pkt_t        tx_pkt,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        rx_err
`ifdef ROUTER_PORT_STATS_EN
    ,
    output logic [15:0] rx_count,
    output logic [15:0] tx_count
`endif
);

    localparam int CW = $clog2(RX_DEPTH) + 1;
    localparam int OW = CW + 1;

    rx_state_t       rx_state;
    logic [7:0]      rx_b0;
    logic [7:0]      rx_b1;
    logic [7:0]      rx_b2;
    logic            rx_push;
    logic            rx_pop;
    logic            rx_start;
    logic            next_reserved;
    logic [OW-1:0]   occ_next;
    logic            free_next;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    pkt_t            rx_assembled;

    tx_state_t       tx_state;
    pkt_t            tx_buf;
    logic [1:0]      tx_idx;

    router_port_pktfifo #(
        .DEPTH (RX_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (rx_push),
        .push_pkt (rx_assembled),
        .pop      (rx_pop),
        .head_pkt (rx_pkt),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign rx_valid = !fifo_empty;

    // A slot is reserved from byte0 until the packet is pushed or aborted,
    // so the reservation is fully implied by the RX state and put_outbound.
    always_comb begin
        rx_push       = (rx_state == RX_B3) && put_outbound;
        rx_pop        = rx_valid && rx_ready;
        rx_start      = (rx_state == RX_IDLE) && put_outbound && free_outbound;
        next_reserved = rx_start ||
                        (((rx_state == RX_B1) || (rx_state == RX_B2)) && put_outbound);
        rx_assembled  = {rx_b0, rx_b1, rx_b2, payload_outbound};
        occ_next      = OW'(fifo_count) + OW'(rx_push) + OW'(next_reserved) - OW'(rx_pop);
        free_next     = occ_next < OW'(RX_DEPTH);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_state      <= RX_IDLE;
            free_outbound <= 1'b0;
            rx_err        <= 1'b0;
            rx_b0         <= '0;
            rx_b1         <= '0;
            rx_b2         <= '0;
        end else begin
            free_outbound <= free_next;
            rx_err        <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (put_outbound) begin
                        if (free_outbound) begin
                            rx_b0    <= payload_outbound;
                            rx_state <= RX_B1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                end
                RX_B1: begin
                    if (put_outbound) begin
                        rx_b1    <= payload_outbound;
                        rx_state <= RX_B2;
                    end else begin
                        rx_err   <= 1'b1;
                        rx_state <= RX_IDLE;
                    end
                end
                RX_B2: begin
                    if (put_outbound) begin
                        rx_b2    <= payload_outbound;
                        rx_state <= RX_B3;
                    end else begin
                        rx_err   <= 1'b1;
                        rx_state <= RX_IDLE;
                    end
                end
                RX_B3: begin
                    if (!put_outbound) begin
                        rx_err <= 1'b1;
                    end
                    rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // tx_idx wrapping to 0 after byte3 gives one extra SEND cycle, which
    // keeps put_inbound low for two cycles before the next byte0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_state        <= TX_IDLE;
            tx_ready        <= 1'b0;
            put_inbound     <= 1'b0;
            payload_inbound <= '0;
            tx_buf          <= '0;
            tx_idx          <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    put_inbound <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        tx_buf   <= tx_pkt;
                        tx_ready <= 1'b0;
                        tx_state <= TX_WAIT;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                TX_WAIT: begin
                    if (free_inbound) begin
                        put_inbound     <= 1'b1;
                        payload_inbound <= pkt_byte(tx_buf, 2'd0);
                        tx_idx          <= 2'd1;
                        tx_state        <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_idx == 2'd0) begin
                        put_inbound <= 1'b0;
                        tx_ready    <= 1'b1;
                        tx_state    <= TX_IDLE;
                    end else begin
                        put_inbound     <= 1'b1;
                        payload_inbound <= pkt_byte(tx_buf, tx_idx);
                        tx_idx          <= tx_idx + 2'd1;
                    end
                end
                default: begin
                    put_inbound <= 1'b0;
                    tx_ready    <= 1'b0;
                    tx_state    <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef ROUTER_PORT_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_count <= rx_count + 16'd1;
            end
            if ((tx_state == TX_SEND) && (tx_idx == 2'd3)) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_port.sv
// Directed bench for router_port: RX deserialize/backpressure/abort, TX
// serialize/wait, back-to-back traffic and reset in mid-packet.
module tb_router_port;
  import router_port_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        free_outbound;
  logic        put_outbound;
  logic [7:0]  payload_outbound;
  logic        free_inbound;
  logic        put_inbound;
  logic [7:0]  payload_inbound;
  pkt_t        rx_pkt;
  logic        rx_valid;
  logic        rx_ready;
  pkt_t        tx_pkt;
  logic        tx_valid;
  logic        tx_ready;
  logic        rx_err;
`ifdef ROUTER_PORT_STATS_EN
  logic [15:0] rx_count;
  logic [15:0] tx_count;
`endif

  int errors = 0;
  int checks = 0;

  router_port #(.RX_DEPTH(2)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .free_outbound    (free_outbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound),
    .free_inbound     (free_inbound),
    .put_inbound      (put_inbound),
    .payload_inbound  (payload_inbound),
    .rx_pkt           (rx_pkt),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .tx_pkt           (tx_pkt),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_err           (rx_err)
`ifdef ROUTER_PORT_STATS_EN
    ,
    .rx_count         (rx_count),
    .tx_count         (tx_count)
`endif
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one edge; inputs are driven and outputs sampled 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    put_outbound     = 1'b1;
    payload_outbound = b;
    tick();
    put_outbound     = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] p);
    send_byte(p[31:24]);
    send_byte(p[23:16]);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (free_outbound !== 1'b0) begin errors++; $display("FAIL reset_free got=%b exp=0", free_outbound); end
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL reset_put got=%b exp=0", put_inbound); end
    checks++; if (payload_inbound !== 8'h00) begin errors++; $display("FAIL reset_payload got=%h exp=00", payload_inbound); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err got=%b exp=0", rx_err); end
    reset_n = 1'b1;
    tick();
    checks++; if (free_outbound !== 1'b1) begin errors++; $display("FAIL post_reset_free got=%b exp=1", free_outbound); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tx_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_single_rx();
    send_pkt(32'h12ABCDEF);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_rx_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_pkt !== 32'h12ABCDEF) begin errors++; $display("FAIL single_rx_pkt got=%h exp=12abcdef", rx_pkt); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL single_rx_err got=%b exp=0", rx_err); end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_rx_pop got=%b exp=0", rx_valid); end
  endtask

  task automatic test_backpressure();
    send_pkt(32'h11223344);
    checks++; if (free_outbound !== 1'b1) begin errors++; $display("FAIL bp_free_one got=%b exp=1", free_outbound); end
    send_byte(8'h56);
    checks++; if (free_outbound !== 1'b0) begin errors++; $display("FAIL bp_free_after_b0 got=%b exp=0", free_outbound); end
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    checks++; if (free_outbound !== 1'b0) begin errors++; $display("FAIL bp_free_full got=%b exp=0", free_outbound); end
    send_byte(8'h5A);
    checks++; if (rx_err !== 1'b1) begin errors++; $display("FAIL bp_rx_err got=%b exp=1", rx_err); end
    tick();
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL bp_rx_err_pulse got=%b exp=0", rx_err); end
    checks++; if (rx_pkt !== 32'h11223344) begin errors++; $display("FAIL bp_head_a got=%h exp=11223344", rx_pkt); end
    pop_one();
    checks++; if (free_outbound !== 1'b1) begin errors++; $display("FAIL bp_free_after_pop got=%b exp=1", free_outbound); end
    checks++; if (rx_pkt !== 32'h56778899) begin errors++; $display("FAIL bp_head_b got=%h exp=56778899", rx_pkt); end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL bp_count_two got=%b exp=0", rx_valid); end
  endtask

  task automatic test_truncated();
    send_byte(8'hDE);
    send_byte(8'hAD);
    tick();
    checks++; if (rx_err !== 1'b1) begin errors++; $display("FAIL trunc_rx_err got=%b exp=1", rx_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL trunc_rx_valid got=%b exp=0", rx_valid); end
    tick();
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL trunc_rx_err_pulse got=%b exp=0", rx_err); end
    send_pkt(32'h98765432);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL trunc_next_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_pkt !== 32'h98765432) begin errors++; $display("FAIL trunc_next_pkt got=%h exp=98765432", rx_pkt); end
    pop_one();
  endtask

  task automatic test_tx();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h34; exp_b[1] = 8'h01; exp_b[2] = 8'h02; exp_b[3] = 8'h03;
    free_inbound = 1'b1;
    tx_pkt   = 32'h34010203;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL tx_wait_put got=%b exp=0", put_inbound); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_drop got=%b exp=0", tx_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (put_inbound !== 1'b1 || payload_inbound !== exp_b[i]) begin errors++; $display("FAIL tx_byte%0d got put=%b data=%h exp put=1 data=%h", i, put_inbound, payload_inbound, exp_b[i]); end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_byte%0d got=%b exp=0", i, tx_ready); end
    end
    tick();
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL tx_end_put got=%b exp=0", put_inbound); end
    checks++; if (payload_inbound !== 8'h03) begin errors++; $display("FAIL tx_hold_payload got=%h exp=03", payload_inbound); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_back got=%b exp=1", tx_ready); end
  endtask

  task automatic test_tx_wait();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hA5; exp_b[1] = 8'hC3; exp_b[2] = 8'hE1; exp_b[3] = 8'h0F;
    free_inbound = 1'b0;
    tx_pkt   = 32'hA5C3E10F;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL txw_hold%0d got=%b exp=0", i, put_inbound); end
    end
    free_inbound = 1'b1;
    tick();
    free_inbound = 1'b0;
    checks++; if (put_inbound !== 1'b1 || payload_inbound !== exp_b[0]) begin errors++; $display("FAIL txw_byte0 got put=%b data=%h exp put=1 data=a5", put_inbound, payload_inbound); end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if (put_inbound !== 1'b1 || payload_inbound !== exp_b[i]) begin errors++; $display("FAIL txw_byte%0d got put=%b data=%h exp put=1 data=%h", i, put_inbound, payload_inbound, exp_b[i]); end
    end
    tick();
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL txw_end got=%b exp=0", put_inbound); end
  endtask

  task automatic test_back_to_back();
    // RX: second packet starts the cycle right after byte3 of the first
    send_pkt(32'h1F2E3D4C);
    send_pkt(32'h5B6A7988);
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL b2b_rx_err got=%b exp=0", rx_err); end
    checks++; if (rx_pkt !== 32'h1F2E3D4C) begin errors++; $display("FAIL b2b_head1 got=%h exp=1f2e3d4c", rx_pkt); end
    pop_one();
    checks++; if (rx_valid !== 1'b1 || rx_pkt !== 32'h5B6A7988) begin errors++; $display("FAIL b2b_head2 got v=%b pkt=%h exp v=1 pkt=5b6a7988", rx_valid, rx_pkt); end
    pop_one();
    // TX: next packet offered at first ready cycle; two low cycles before byte0
    free_inbound = 1'b1;
    tx_pkt   = 32'hC0010203;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (4) tick();
    checks++; if (put_inbound !== 1'b1 || payload_inbound !== 8'h03) begin errors++; $display("FAIL b2b_tx_first_b3 got put=%b data=%h exp put=1 data=03", put_inbound, payload_inbound); end
    tick();
    checks++; if (tx_ready !== 1'b1 || put_inbound !== 1'b0) begin errors++; $display("FAIL b2b_tx_gap1 got ready=%b put=%b exp ready=1 put=0", tx_ready, put_inbound); end
    tx_pkt   = 32'hD4050607;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL b2b_tx_gap2 got=%b exp=0", put_inbound); end
    tick();
    checks++; if (put_inbound !== 1'b1 || payload_inbound !== 8'hD4) begin errors++; $display("FAIL b2b_tx_second_b0 got put=%b data=%h exp put=1 data=d4", put_inbound, payload_inbound); end
    repeat (4) tick();
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL b2b_tx_second_end got=%b exp=0", put_inbound); end
  endtask

  task automatic test_reset_mid();
    send_pkt(32'h0A0B0C0D);
    free_inbound = 1'b1;
    tx_pkt   = 32'hE7112233;
    tx_valid = 1'b1;
    send_byte(8'h21);
    tx_valid = 1'b0;
    send_byte(8'h43);
    checks++; if (put_inbound !== 1'b1 || rx_valid !== 1'b1) begin errors++; $display("FAIL mid_busy got put=%b rx_valid=%b exp put=1 rx_valid=1", put_inbound, rx_valid); end
    reset_n = 1'b0;
    tick();
    checks++; if (put_inbound !== 1'b0) begin errors++; $display("FAIL mid_put got=%b exp=0", put_inbound); end
    checks++; if (free_outbound !== 1'b0) begin errors++; $display("FAIL mid_free got=%b exp=0", free_outbound); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_ready !== 1'b0 || payload_inbound !== 8'h00) begin errors++; $display("FAIL mid_tx got ready=%b data=%h exp ready=0 data=00", tx_ready, payload_inbound); end
    reset_n = 1'b1;
    tick();
    checks++; if (free_outbound !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL mid_release got free=%b ready=%b exp 1 1", free_outbound, tx_ready); end
    send_pkt(32'h6C5D4E3F);
    checks++; if (rx_valid !== 1'b1 || rx_pkt !== 32'h6C5D4E3F) begin errors++; $display("FAIL mid_fresh_rx got v=%b pkt=%h exp v=1 pkt=6c5d4e3f", rx_valid, rx_pkt); end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_fresh_pop got=%b exp=0", rx_valid); end
    tx_pkt   = 32'h89ABCDEF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    checks++; if (put_inbound !== 1'b1 || payload_inbound !== 8'h89) begin errors++; $display("FAIL mid_fresh_tx_b0 got put=%b data=%h exp put=1 data=89", put_inbound, payload_inbound); end
    repeat (3) tick();
    checks++; if (put_inbound !== 1'b1 || payload_inbound !== 8'hEF) begin errors++; $display("FAIL mid_fresh_tx_b3 got put=%b data=%h exp put=1 data=ef", put_inbound, payload_inbound); end
  endtask

  initial begin
    reset_n          = 1'b0;
    put_outbound     = 1'b0;
    payload_outbound = 8'h00;
    free_inbound     = 1'b0;
    rx_ready         = 1'b0;
    tx_pkt           = '0;
    tx_valid         = 1'b0;
    #1;
    test_reset();
    test_single_rx();
    test_backpressure();
    test_truncated();
    test_tx();
    test_tx_wait();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
